// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_e      : fetch FSM encoding (INIT / RUN / FULL)
//   fetch_entry_t      : one instruction-buffer entry, {pc, ins}
//   DEFAULT_RESET_PC   : PC loaded on reset unless overridden
//   DEFAULT_FIFO_DEPTH : instruction buffer entries unless overridden
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } fetch_entry_t;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'd0;
  localparam int          DEFAULT_FIFO_DEPTH = 2;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between the fetch stage and decode.
// First-word-fall-through with an empty-bypass: when the buffer is empty a
// pushed entry is visible at the head in the same cycle, so a read returned
// from memory can be consumed without first landing in storage.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : drop every stored entry (and any entry pushed this cycle)
//   push       : write push_entry
//   pop        : consume the head (only meaningful while out_valid)
//   out_valid  : head holds an entry (stored or bypassed)
//   head       : current head entry, zero when nothing is present
//   count      : number of stored entries
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output logic         out_valid,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          empty, bypass, wr_en, rd_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty     = (count == '0);
  assign bypass    = empty && push;
  assign out_valid = !empty || push;
  // A bypassed entry that is popped in the same cycle never needs storage.
  assign wr_en     = push && !(bypass && pop);
  assign rd_en     = pop && !empty;

  always_comb begin
    head = '0;
    if (!empty)    head = mem[rd_ptr];
    else if (push) head = push_entry;
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word reads to an external synchronous
// instruction memory, tags each read with its PC and buffers returned
// instructions for decode. Reads are issued only against free buffer credit
// (buffer slots not already occupied or claimed by an in-flight read), so the
// buffer can never overflow.
//   clk, rst        : clock, synchronous active-high reset
//   redirect        : execute-stage control transfer (flushes, reloads PC)
//   redirect_pc     : target word PC
//   ins_ready       : downstream accepts ins/pc this cycle
//   ins_valid       : ins/pc hold a valid instruction
//   ins, pc         : instruction word and its word PC (zero when invalid)
//   imem_req        : memory read strobe
//   imem_addr       : memory word address (low bits of fetch PC)
//   imem_rdata      : read data, valid the cycle after imem_req
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IMEM_AW    = 8,
  parameter int          FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               ins_ready,
  output logic               ins_valid,
  output logic [31:0]        ins,
  output logic [31:0]        pc,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata
);

  localparam int         CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  fetch_state_e  state, state_nxt;
  logic [31:0]   fetch_pc, tag;
  logic          inflight;
  logic [CW-1:0] count;
  logic [CW:0]   occ_now, occ_nxt;
  logic          credit_ok, credit_ok_nxt;
  logic          push, pop;
  fetch_entry_t  push_entry, head;

  // Slots in use = stored entries plus the read whose data is still on its way.
  assign occ_now   = {1'b0, count} + (CW + 1)'(inflight);
  assign credit_ok = occ_now < DEPTH_W;

  assign imem_req  = (state == ST_RUN) && credit_ok && !redirect && !rst;
  assign imem_addr = fetch_pc[IMEM_AW-1:0];

  // A returning read is dropped when a redirect kills it in its landing cycle.
  assign push       = inflight && !redirect && !rst;
  assign push_entry = '{pc: tag, ins: imem_rdata};
  assign pop        = ins_valid && ins_ready;

  // Occupancy as it will be after this edge. The FSM tracks credit one cycle
  // ahead so a slot freed by a pop is reused on the very next cycle, which
  // keeps the stream back-to-back when a stall is released.
  always_comb begin
    occ_nxt = '0;
    if (!redirect)
      occ_nxt = {1'b0, count} + (CW + 1)'(push) - (CW + 1)'(pop)
              + (CW + 1)'(imem_req);
  end
  assign credit_ok_nxt = occ_nxt < DEPTH_W;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_INIT: state_nxt = ST_RUN;
      ST_RUN:  if (!credit_ok_nxt) state_nxt = ST_FULL;
      ST_FULL: if (credit_ok_nxt)  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      fetch_pc <= RESET_PC;
      tag      <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= imem_req;
      if (redirect) begin
        fetch_pc <= redirect_pc;
      end else if (imem_req) begin
        fetch_pc <= fetch_pc + 32'd1;
        tag      <= fetch_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .out_valid  (ins_valid),
    .head       (head),
    .count      (count)
  );

  assign ins = head.ins;
  assign pc  = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          ins_ready = 1'b0;
  logic          ins_valid;
  logic [31:0]   ins, pc;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = '0;

  int total = 0;
  int bad   = 0;

  fetch_unit #(
    .RESET_PC   (32'd0),
    .IMEM_AW    (AW),
    .FIFO_DEPTH (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ins_ready   (ins_ready),
    .ins_valid   (ins_valid),
    .ins         (ins),
    .pc          (pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: word n holds 0x1000_0000 + n.
  always @(posedge clk)
    if (imem_req) imem_rdata <= 32'h1000_0000 + {24'd0, imem_addr};

  // Hold reset over two edges, then release it mid-cycle; the cycle in which
  // rst drops is the INIT cycle ("c0").
  task automatic reset_to_c0();
    rst = 1'b1; redirect = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ins_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (ins_valid !== 1'b0 || ins !== 32'd0 || pc !== 32'd0 || imem_req !== 1'b0 || imem_addr !== 8'h00) begin
      bad++;
      $display("FAIL reset_state: valid=%b ins=%h pc=%h req=%b addr=%h, want 0 0 0 0 00", ins_valid, ins, pc, imem_req, imem_addr);
    end
    rst = 1'b0; #1;
    total++;
    if (imem_req !== 1'b0 || ins_valid !== 1'b0) begin
      bad++;
      $display("FAIL init_cycle: req=%b valid=%b, want 0 0", imem_req, ins_valid);
    end
  endtask

  // Continues from test_reset's INIT cycle.
  task automatic test_stream();
    @(negedge clk); #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00 || ins_valid !== 1'b0) begin
      bad++;
      $display("FAIL first_req: req=%b addr=%h valid=%b, want 1 00 0", imem_req, imem_addr, ins_valid);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      total++;
      if (ins_valid !== 1'b1 || pc !== 32'(k) || ins !== 32'h1000_0000 + 32'(k) || imem_req !== 1'b1 || imem_addr !== 8'(k + 1)) begin
        bad++;
        $display("FAIL stream[%0d]: valid=%b pc=%h ins=%h req=%b addr=%h, want 1 %h %h 1 %h",
                 k, ins_valid, pc, ins, imem_req, imem_addr, 32'(k), 32'h1000_0000 + 32'(k), 8'(k + 1));
      end
    end
  endtask

  task automatic test_stall();
    reset_to_c0();
    ins_ready = 1'b1;
    @(negedge clk);                       // c1
    @(negedge clk); ins_ready = 1'b0;     // c2: first valid, held
    for (int c = 2; c <= 6; c++) begin
      if (c > 2) @(negedge clk);
      #1;
      total++;
      if (ins_valid !== 1'b1 || pc !== 32'd0 || ins !== 32'h1000_0000) begin
        bad++;
        $display("FAIL stall_hold[c%0d]: valid=%b pc=%h ins=%h, want 1 00000000 10000000", c, ins_valid, pc, ins);
      end
      if (c >= 4) begin
        total++;
        if (imem_req !== 1'b0) begin
          bad++;
          $display("FAIL stall_full_req[c%0d]: req=%b, want 0", c, imem_req);
        end
      end
    end
    @(negedge clk); ins_ready = 1'b1; #1; // c7: release
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      total++;
      if (ins_valid !== 1'b1 || pc !== 32'(k) || ins !== 32'h1000_0000 + 32'(k)) begin
        bad++;
        $display("FAIL stall_release[%0d]: valid=%b pc=%h ins=%h, want 1 %h %h",
                 k, ins_valid, pc, ins, 32'(k), 32'h1000_0000 + 32'(k));
      end
      if (k == 1) begin
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h03) begin
          bad++;
          $display("FAIL stall_refetch: req=%b addr=%h, want 1 03", imem_req, imem_addr);
        end
      end
    end
  endtask

  // Two buffered entries plus one read in flight when the redirect lands.
  task automatic test_redirect();
    reset_to_c0();
    ins_ready = 1'b1;
    @(negedge clk);                       // c1
    @(negedge clk); ins_ready = 1'b0;     // c2
    @(negedge clk);                       // c3
    @(negedge clk);                       // c4
    redirect = 1'b1; redirect_pc = 32'h40; #1;
    total++;
    if (imem_req !== 1'b0) begin
      bad++;
      $display("FAIL redir_req_low: req=%b, want 0", imem_req);
    end
    @(negedge clk); redirect = 1'b0; ins_ready = 1'b1; #1;
    total++;
    if (ins_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h40) begin
      bad++;
      $display("FAIL redir_issue: valid=%b pc=%h req=%b addr=%h, want 0 - 1 40", ins_valid, pc, imem_req, imem_addr);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      total++;
      if (ins_valid !== 1'b1 || pc !== 32'h40 + 32'(k) || ins !== 32'h1000_0040 + 32'(k)) begin
        bad++;
        $display("FAIL redir_target[%0d]: valid=%b pc=%h ins=%h, want 1 %h %h",
                 k, ins_valid, pc, ins, 32'h40 + 32'(k), 32'h1000_0040 + 32'(k));
      end
    end
  endtask

  // Redirect in the same cycle as an accepted handshake on a buffered head.
  task automatic test_redirect_accept();
    reset_to_c0();
    ins_ready = 1'b1;
    @(negedge clk);                       // c1
    @(negedge clk); ins_ready = 1'b0;     // c2
    @(negedge clk);                       // c3
    @(negedge clk);                       // c4
    ins_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h80; #1;
    total++;
    if (ins_valid !== 1'b1 || pc !== 32'd0) begin
      bad++;
      $display("FAIL redir_acc_head: valid=%b pc=%h, want 1 00000000", ins_valid, pc);
    end
    @(negedge clk); redirect = 1'b0; #1;
    total++;
    if (ins_valid !== 1'b0 || ins !== 32'd0 || pc !== 32'd0 || imem_addr !== 8'h80) begin
      bad++;
      $display("FAIL redir_acc_empty: valid=%b pc=%h ins=%h addr=%h, want 0 0 0 80", ins_valid, pc, ins, imem_addr);
    end
    @(negedge clk); #1;
    total++;
    if (ins_valid !== 1'b1 || pc !== 32'h80 || ins !== 32'h1000_0080) begin
      bad++;
      $display("FAIL redir_acc_target: valid=%b pc=%h ins=%h, want 1 00000080 10000080", ins_valid, pc, ins);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk); ins_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; #1;
    @(negedge clk); redirect = 1'b0; #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 8'hFF || ins_valid !== 1'b0) begin
      bad++;
      $display("FAIL wrap_addr_ff: req=%b addr=%h valid=%b, want 1 ff 0", imem_req, imem_addr, ins_valid);
    end
    @(negedge clk); #1;
    total++;
    if (imem_addr !== 8'h00 || ins_valid !== 1'b1 || pc !== 32'hFFFF_FFFF || ins !== 32'h1000_00FF) begin
      bad++;
      $display("FAIL wrap_top: addr=%h valid=%b pc=%h ins=%h, want 00 1 ffffffff 100000ff", imem_addr, ins_valid, pc, ins);
    end
    @(negedge clk); #1;
    total++;
    if (imem_addr !== 8'h01 || ins_valid !== 1'b1 || pc !== 32'd0 || ins !== 32'h1000_0000) begin
      bad++;
      $display("FAIL wrap_zero: addr=%h valid=%b pc=%h ins=%h, want 01 1 00000000 10000000", imem_addr, ins_valid, pc, ins);
    end
  endtask

  // Reset (with a competing redirect) while the buffer is full.
  task automatic test_reset_mid();
    reset_to_c0();
    ins_ready = 1'b1;
    @(negedge clk);                       // c1
    @(negedge clk); ins_ready = 1'b0;     // c2
    repeat (3) @(negedge clk);            // c5: buffer full
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h55;
    @(negedge clk); redirect = 1'b0; #1;
    total++;
    if (ins_valid !== 1'b0 || ins !== 32'd0 || pc !== 32'd0 || imem_req !== 1'b0 || imem_addr !== 8'h00) begin
      bad++;
      $display("FAIL rst_mid_zero: valid=%b ins=%h pc=%h req=%b addr=%h, want 0 0 0 0 00", ins_valid, ins, pc, imem_req, imem_addr);
    end
    rst = 1'b0; ins_ready = 1'b1; #1;
    @(negedge clk); #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00 || ins_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_req: req=%b addr=%h valid=%b, want 1 00 0", imem_req, imem_addr, ins_valid);
    end
    @(negedge clk); #1;
    total++;
    if (ins_valid !== 1'b1 || pc !== 32'd0 || ins !== 32'h1000_0000) begin
      bad++;
      $display("FAIL rst_mid_restart: valid=%b pc=%h ins=%h, want 1 00000000 10000000", ins_valid, pc, ins);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_accept();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'd0, word-addressed PC loaded on reset.
REQ-002 Parameter IMEM_AW, default 8, instruction memory address width in words.
REQ-003 Parameter FIFO_DEPTH, default 2, instruction buffer entries.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 redirect  input  1  execute-stage control transfer valid.
REQ-007 redirect_pc  input  32  target word PC (execute nextpc).
REQ-008 ins_ready  input  1  decode/execute accepts current instruction.
REQ-009 ins_valid  output  1  ins/pc hold a valid instruction.
REQ-010 ins  output  32  instruction word to decode.
REQ-011 pc  output  32  word PC of ins.
REQ-012 imem_req  output  1  instruction memory read strobe.
REQ-013 imem_addr  output  IMEM_AW  instruction memory word address.
REQ-014 imem_rdata  input  32  read data, valid exactly one cycle after imem_req.

Function
REQ-015 PC is word-addressed; sequential successor SHALL be fetch_pc + 32'd1, 32-bit wrap 0xFFFFFFFF -> 0.
REQ-016 imem_addr SHALL equal fetch_pc[IMEM_AW-1:0] (modulo wrap, upper bits ignored).
REQ-017 FSM states: INIT, RUN, FULL; INIT -> RUN after one cycle; RUN -> FULL when credit = 0; FULL -> RUN when credit > 0.
REQ-018 Credit = FIFO_DEPTH - occupancy - inflight; imem_req SHALL assert only in RUN with credit > 0 and redirect = 0.
REQ-019 Each imem_req cycle SHALL advance fetch_pc by 1 and record tag (fetch_pc) for the in-flight read.
REQ-020 One cycle after imem_req, {tag, imem_rdata} SHALL be pushed into the FIFO unless killed.
REQ-021 ins_valid SHALL equal FIFO non-empty; ins/pc SHALL be FIFO head; ins=0, pc=0 when empty.
REQ-022 Pop on ins_valid & ins_ready; push and pop in same cycle SHALL both occur; occupancy unchanged.
REQ-023 ins/pc SHALL remain stable while ins_valid & !ins_ready.
REQ-024 redirect SHALL have priority: flush FIFO, kill in-flight read, fetch_pc <= redirect_pc, imem_req = 0 that cycle; handshake in that cycle counts as accepted.
REQ-025 First fetch from redirect_pc SHALL issue the cycle after redirect; its ins_valid the cycle after that.
REQ-026 Steady state with ins_ready = 1 SHALL sustain one instruction per cycle.
REQ-027 FIFO SHALL never overflow; no push occurs without prior credit.

Reset
REQ-028 On rst: state=INIT, fetch_pc=RESET_PC, FIFO empty, inflight=0, ins_valid=0, imem_req=0, ins=0, pc=0.
REQ-029 rst asserted mid-operation SHALL discard in-flight read and buffered entries; rst overrides redirect.
REQ-030 First imem_req SHALL occur one cycle after rst deasserts (INIT), first ins_valid one cycle later.

Structure
REQ-031 Shared package fetch_pkg SHALL hold FSM state encoding, default RESET_PC, default FIFO_DEPTH.
REQ-032 Instruction buffer SHALL be a sub-module fetch_fifo (parameterised depth, 64-bit {pc, ins} entries, push/pop/flush, count).
REQ-033 Instruction memory is external (instructionMemory, synchronous read); not instantiated here.

Verification
REQ-034 Reset release, ins_ready=1, memory word n = 0x1000_0000+n -> ins_valid from cycle 2, pc 0,1,2,3 with ins 0x10000000..0x10000003 on consecutive cycles.
REQ-035 ins_ready=0 for 5 cycles after first valid -> ins/pc hold pc=0, exactly FIFO_DEPTH entries buffered, imem_req low in FULL; release -> pc 0,1,2 back-to-back, no loss/duplication.
REQ-036 redirect=1, redirect_pc=0x40 while FIFO holds 2 entries and a read in flight -> next ins_valid pc=0x40, no stale pc reaches output.
REQ-037 rst pulsed mid-stream with FIFO full -> next-cycle outputs all zero, restart at RESET_PC per REQ-030.
REQ-038 fetch_pc = 0xFFFFFFFF fetched via redirect -> imem_addr 0xFF then 0x00, pc output 0xFFFFFFFF then 0x00000000.
REQ-039 redirect and ins_valid & ins_ready in same cycle -> head consumed once, FIFO empty next cycle, no extra pop.
